// File: rtl/flash_read_arbiter_if.sv
// Bus bundle between the two flash requesters (CPU loader on port 0, audio
// sample DMA on port 1), the read arbiter and the SPI flash read engine.
// The arbiter connects through the slave modport; the surrounding system
// (requesters plus engine) connects through the master modport.
interface flash_read_arbiter_if #(
  parameter int ADDR_BITS  = 24,
  parameter int DATA_BITS  = 16,
  parameter int COUNT_BITS = 12
);
  // Requester port 0
  logic                  req0_valid;
  logic [ADDR_BITS-1:0]  req0_addr;
  logic [COUNT_BITS-1:0] req0_count;
  logic                  req0_ready;
  logic [DATA_BITS-1:0]  req0_data;
  logic                  req0_data_valid;
  logic                  req0_done;

  // Requester port 1
  logic                  req1_valid;
  logic [ADDR_BITS-1:0]  req1_addr;
  logic [COUNT_BITS-1:0] req1_count;
  logic                  req1_ready;
  logic [DATA_BITS-1:0]  req1_data;
  logic                  req1_data_valid;
  logic                  req1_done;

  // Flash read engine command/response
  logic                  fl_start;
  logic [ADDR_BITS-1:0]  fl_addr;
  logic [COUNT_BITS-1:0] fl_count;
  logic                  fl_busy;
  logic [DATA_BITS-1:0]  fl_data;
  logic                  fl_data_valid;
  logic                  fl_done;

  logic                  grant_id;

  modport slave (
    input  req0_valid, req0_addr, req0_count,
    output req0_ready, req0_data, req0_data_valid, req0_done,
    input  req1_valid, req1_addr, req1_count,
    output req1_ready, req1_data, req1_data_valid, req1_done,
    output fl_start, fl_addr, fl_count,
    input  fl_busy, fl_data, fl_data_valid, fl_done,
    output grant_id
  );

  modport master (
    output req0_valid, req0_addr, req0_count,
    input  req0_ready, req0_data, req0_data_valid, req0_done,
    output req1_valid, req1_addr, req1_count,
    input  req1_ready, req1_data, req1_data_valid, req1_done,
    input  fl_start, fl_addr, fl_count,
    output fl_busy, fl_data, fl_data_valid, fl_done,
    input  grant_id
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares the single SPI flash read engine between the CPU
// loader (port 0) and the drum-machine sample DMA (port 1). Requests are
// arbitrated round-robin, one start/address/count command is issued to the
// engine, and returned words plus a completion pulse are routed back to the
// granted port with one cycle of registration.
//
// Optional feature macro: FLASH_ARB_BURST_SPLIT_EN
//   When defined, requests longer than MAX_BURST words are split into
//   MAX_BURST-word chunks with per-port resume context, and the engine is
//   re-arbitrated after every chunk. When undefined, each request is issued as
//   a single command and holds the engine until fl_done.
module flash_read_arbiter #(
  parameter int ADDR_BITS  = 24,
  parameter int DATA_BITS  = 16,
  parameter int COUNT_BITS = 12,
  parameter int MAX_BURST  = 16
) (
  input  logic                clk,
  input  logic                rst,
  flash_read_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,    // waiting for a request and an idle engine
    S_ISSUE,   // fl_start strobe cycle
    S_STREAM,  // forwarding words until fl_done
    S_ZERO,    // zero-length request: ready shown, done follows
    S_POST     // done shown; enforces a gap before the next grant
  } state_t;

  // Byte addresses are word aligned; bit 0 of a request address is dropped.
  localparam logic [ADDR_BITS-1:0] ADDR_ALIGN_MASK = ~ADDR_BITS'(1);

  // A chunk length must be representable in the command count field.
  if (MAX_BURST < 1 || MAX_BURST >= (1 << COUNT_BITS)) begin : g_cfg_check
    $error("flash_read_arbiter: MAX_BURST must be 1..2**COUNT_BITS-1");
  end

  state_t                     state_q, state_n;
  logic                       last_grant_q, last_grant_n;
  logic                       grant_q, grant_n;
  logic [1:0]                 ready_q, ready_n;
  logic [1:0]                 dv_q, dv_n;
  logic [1:0]                 done_q, done_n;
  logic [1:0][DATA_BITS-1:0]  data_q, data_n;
  logic [ADDR_BITS-1:0]       cmd_addr_q, cmd_addr_n;
  logic [COUNT_BITS-1:0]      cmd_count_q, cmd_count_n;

  logic [1:0]                 req_valid;
  logic [1:0][ADDR_BITS-1:0]  req_addr;
  logic [1:0][COUNT_BITS-1:0] req_count;
  logic [1:0]                 cand;
  logic                       sel;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_addr  = {bus.req1_addr,  bus.req0_addr};
  assign req_count = {bus.req1_count, bus.req0_count};

  // Round-robin pick: a lone candidate wins; on a tie the port that did not
  // own the engine last time wins.
  function automatic logic pick_port(input logic [1:0] c, input logic last);
    if (c == 2'b11) return ~last;
    return c[1];
  endfunction

`ifdef FLASH_ARB_BURST_SPLIT_EN
  localparam logic [COUNT_BITS-1:0] BURST_WORDS = COUNT_BITS'(MAX_BURST);
  localparam logic [ADDR_BITS-1:0]  BURST_BYTES = ADDR_BITS'(2 * MAX_BURST);

  // Per-port resume context: a set ctx_act bit marks a suspended request
  // that still competes for the engine without its requester holding valid.
  logic [1:0]                 ctx_act_q, ctx_act_n;
  logic [1:0][ADDR_BITS-1:0]  ctx_addr_q, ctx_addr_n;
  logic [1:0][COUNT_BITS-1:0] ctx_rem_q, ctx_rem_n;
  logic [ADDR_BITS-1:0]       base_addr;
  logic [COUNT_BITS-1:0]      base_rem;

  assign cand      = req_valid | ctx_act_q;
  assign base_addr = ctx_act_q[sel] ? ctx_addr_q[sel] : (req_addr[sel] & ADDR_ALIGN_MASK);
  assign base_rem  = ctx_act_q[sel] ? ctx_rem_q[sel]  : req_count[sel];
`else
  assign cand = req_valid;
`endif

  assign sel = pick_port(cand, last_grant_q);

  // Next-state, arbitration and response routing.
  always_comb begin
    state_n      = state_q;
    last_grant_n = last_grant_q;
    grant_n      = grant_q;
    ready_n      = '0;
    dv_n         = '0;
    done_n       = '0;
    data_n       = data_q;
    cmd_addr_n   = cmd_addr_q;
    cmd_count_n  = cmd_count_q;
`ifdef FLASH_ARB_BURST_SPLIT_EN
    ctx_act_n    = ctx_act_q;
    ctx_addr_n   = ctx_addr_q;
    ctx_rem_n    = ctx_rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if ((|cand) && !bus.fl_busy) begin
          grant_n = sel;
`ifdef FLASH_ARB_BURST_SPLIT_EN
          // ready only on first acceptance; resumed chunks are silent.
          ready_n[sel]    = ~ctx_act_q[sel];
          cmd_addr_n      = base_addr;
          cmd_count_n     = (base_rem > BURST_WORDS) ? BURST_WORDS : base_rem;
          ctx_act_n[sel]  = 1'b1;
          ctx_addr_n[sel] = base_addr;
          ctx_rem_n[sel]  = base_rem;
          state_n         = (base_rem == '0) ? S_ZERO : S_ISSUE;
`else
          ready_n[sel] = 1'b1;
          cmd_addr_n   = req_addr[sel] & ADDR_ALIGN_MASK;
          cmd_count_n  = req_count[sel];
          state_n      = (req_count[sel] == '0) ? S_ZERO : S_ISSUE;
`endif
        end
      end

      S_ISSUE: state_n = S_STREAM;

      S_STREAM: begin
        if (bus.fl_data_valid) begin
          dv_n[grant_q]   = 1'b1;
          data_n[grant_q] = bus.fl_data;
        end
        // fl_done closes the command even if fewer words than asked arrived.
        if (bus.fl_done) begin
          last_grant_n = grant_q;
          state_n      = S_POST;
`ifdef FLASH_ARB_BURST_SPLIT_EN
          ctx_rem_n[grant_q]  = ctx_rem_q[grant_q] - cmd_count_q;
          ctx_addr_n[grant_q] = ctx_addr_q[grant_q] + BURST_BYTES;
          if (ctx_rem_q[grant_q] <= cmd_count_q) begin
            done_n[grant_q]    = 1'b1;
            ctx_act_n[grant_q] = 1'b0;
          end
`else
          done_n[grant_q] = 1'b1;
`endif
        end
      end

      S_ZERO: begin
        done_n[grant_q] = 1'b1;
        last_grant_n    = grant_q;
        state_n         = S_POST;
`ifdef FLASH_ARB_BURST_SPLIT_EN
        ctx_act_n[grant_q] = 1'b0;
`endif
      end

      S_POST: begin
        grant_n = 1'b0;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; reset clears every output and pending context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      ready_q      <= '0;
      dv_q         <= '0;
      done_q       <= '0;
      data_q       <= '0;
      cmd_addr_q   <= '0;
      cmd_count_q  <= '0;
`ifdef FLASH_ARB_BURST_SPLIT_EN
      ctx_act_q    <= '0;
      ctx_addr_q   <= '0;
      ctx_rem_q    <= '0;
`endif
    end else begin
      state_q      <= state_n;
      last_grant_q <= last_grant_n;
      grant_q      <= grant_n;
      ready_q      <= ready_n;
      dv_q         <= dv_n;
      done_q       <= done_n;
      data_q       <= data_n;
      cmd_addr_q   <= cmd_addr_n;
      cmd_count_q  <= cmd_count_n;
`ifdef FLASH_ARB_BURST_SPLIT_EN
      ctx_act_q    <= ctx_act_n;
      ctx_addr_q   <= ctx_addr_n;
      ctx_rem_q    <= ctx_rem_n;
`endif
    end
  end

  assign bus.req0_ready      = ready_q[0];
  assign bus.req0_data_valid = dv_q[0];
  assign bus.req0_data       = data_q[0];
  assign bus.req0_done       = done_q[0];
  assign bus.req1_ready      = ready_q[1];
  assign bus.req1_data_valid = dv_q[1];
  assign bus.req1_data       = data_q[1];
  assign bus.req1_done       = done_q[1];
  assign bus.fl_start        = (state_q == S_ISSUE);
  assign bus.fl_addr         = cmd_addr_q;
  assign bus.fl_count        = cmd_count_q;
  assign bus.grant_id        = grant_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed testbench for flash_read_arbiter: plays requesters and the flash
// engine, checks every response against hand-computed values.
module tb_flash_read_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  flash_read_arbiter_if bus ();

  flash_read_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({bus.req0_ready, bus.req0_data_valid, bus.req0_done, bus.req0_data,
                 bus.req1_ready, bus.req1_data_valid, bus.req1_done, bus.req1_data,
                 bus.fl_start, bus.fl_addr, bus.fl_count, bus.grant_id});
  endfunction

  function automatic logic rdy(input logic p);
    return p ? bus.req1_ready : bus.req0_ready;
  endfunction
  function automatic logic dvl(input logic p);
    return p ? bus.req1_data_valid : bus.req0_data_valid;
  endfunction
  function automatic logic [15:0] dat(input logic p);
    return p ? bus.req1_data : bus.req0_data;
  endfunction
  function automatic logic dne(input logic p);
    return p ? bus.req1_done : bus.req0_done;
  endfunction

  task automatic set_req(input logic p, input logic v, input logic [23:0] a, input logic [11:0] n);
    if (p) begin
      bus.req1_valid = v; bus.req1_addr = a; bus.req1_count = n;
    end else begin
      bus.req0_valid = v; bus.req0_addr = a; bus.req0_count = n;
    end
  endtask

  task automatic drop_req(input logic p);
    if (p) bus.req1_valid = 1'b0;
    else   bus.req0_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.fl_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Waits for a command, checks it, then plays the engine for n words with
  // fl_done on the last word and checks each routed word.
  task automatic serve(input logic p, input logic [23:0] a, input logic [11:0] n,
                       input logic [15:0] seed, input bit exp_rdy, input bit exp_done);
    bit ok;
    int cnt;
    cnt = int'(n);
    wait_start(ok);
    chk("start_seen", 128'(ok), 128'(1));
    if (!ok) return;
    chk("cmd_addr",    128'(bus.fl_addr),  128'(a));
    chk("cmd_count",   128'(bus.fl_count), 128'(n));
    chk("grant_id",    128'(bus.grant_id), 128'(p));
    chk("ready",       128'(rdy(p)),       128'(exp_rdy));
    chk("ready_other", 128'(rdy(~p)),      128'(0));
    if (exp_rdy) drop_req(p);
    bus.fl_busy = 1'b1;
    step();
    for (int k = 0; k < cnt; k++) begin
      bus.fl_data_valid = 1'b1;
      bus.fl_data       = seed + 16'(k);
      bus.fl_done       = (k == cnt - 1);
      step();
      chk("data_valid", 128'(dvl(p)),       128'(1));
      chk("data",       128'(dat(p)),       128'(seed + 16'(k)));
      chk("other_dv",   128'(dvl(~p)),      128'(0));
      chk("done",       128'(dne(p)),       128'((k == cnt - 1) && exp_done));
      chk("start_busy", 128'(bus.fl_start), 128'(0));
    end
    bus.fl_data_valid = 1'b0;
    bus.fl_done       = 1'b0;
    bus.fl_busy       = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    set_req(1'b0, 1'b0, 24'h0, 12'h0);
    set_req(1'b1, 1'b0, 24'h0, 12'h0);
    bus.fl_busy = 1'b0; bus.fl_data = 16'h0; bus.fl_data_valid = 1'b0; bus.fl_done = 1'b0;
    step(3);
    chk("reset_outputs", all_outs(), 128'(0));
    rst = 1'b0;
    step();

    // 1: single port-0 read of 4 words
    set_req(1'b0, 1'b1, 24'h010000, 12'd4);
    step();
    serve(1'b0, 24'h010000, 12'd4, 16'hA000, 1'b1, 1'b1);
    step();
    chk("t1_req1_quiet", 128'({bus.req1_ready, bus.req1_data_valid, bus.req1_done, bus.req1_data}), 128'(0));
    chk("t1_done_single", 128'(bus.req0_done), 128'(0));
    chk("t1_grant_idle",  128'(bus.grant_id),  128'(0));

    // 2: both ports valid right after reset, then again
    rst = 1'b1; step(); rst = 1'b0; step();
    set_req(1'b0, 1'b1, 24'h000200, 12'd2);
    set_req(1'b1, 1'b1, 24'h000400, 12'd3);
    step();
    serve(1'b0, 24'h000200, 12'd2, 16'hB000, 1'b1, 1'b1);
    serve(1'b1, 24'h000400, 12'd3, 16'hB100, 1'b1, 1'b1);
    set_req(1'b0, 1'b1, 24'h000600, 12'd2);
    set_req(1'b1, 1'b1, 24'h000800, 12'd2);
    serve(1'b0, 24'h000600, 12'd2, 16'hB200, 1'b1, 1'b1);
    serve(1'b1, 24'h000800, 12'd2, 16'hB300, 1'b1, 1'b1);

    // 3: zero-length request on port 1
    step(2);
    set_req(1'b1, 1'b1, 24'h003000, 12'd0);
    step();
    chk("t3_ready",     128'(bus.req1_ready), 128'(1));
    chk("t3_no_start1", 128'(bus.fl_start),   128'(0));
    drop_req(1'b1);
    step();
    chk("t3_done",      128'(bus.req1_done),  128'(1));
    chk("t3_no_start2", 128'(bus.fl_start),   128'(0));
    step();
    chk("t3_done_pulse", 128'(bus.req1_done), 128'(0));

    // 4: engine busy blocks acceptance
    step(2);
    bus.fl_busy = 1'b1;
    set_req(1'b0, 1'b1, 24'h005000, 12'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.req0_ready || bus.fl_start) seen = 1'b1;
    end
    chk("t4_blocked", 128'(seen), 128'(0));
    bus.fl_busy = 1'b0;
    step();
    chk("t4_ready_after_busy", 128'(bus.req0_ready), 128'(1));
    serve(1'b0, 24'h005000, 12'd1, 16'hC000, 1'b1, 1'b1);

    // 5: reset in the middle of an 8-word transfer
    step(2);
    set_req(1'b0, 1'b1, 24'h006000, 12'd8);
    step();
    chk("t5_start", 128'(bus.fl_start), 128'(1));
    drop_req(1'b0);
    bus.fl_busy = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      bus.fl_data_valid = 1'b1;
      bus.fl_data       = 16'hD000 + 16'(k);
      step();
      chk("t5_word", 128'(bus.req0_data), 128'(16'hD000 + 16'(k)));
    end
    rst = 1'b1;
    bus.fl_data = 16'hD002;
    step();
    chk("t5_reset_mid", all_outs(), 128'(0));
    rst = 1'b0;
    bus.fl_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.fl_data_valid = 1'b1;
      bus.fl_data       = 16'hE000 + 16'(k);
      bus.fl_done       = k[0];
      step();
      chk("t5_ignored", all_outs(), 128'(0));
    end
    bus.fl_data_valid = 1'b0;
    bus.fl_done       = 1'b0;

`ifdef FLASH_ARB_BURST_SPLIT_EN
    // 6: split 40-word request interleaved with a 4-word request
    step(2);
    set_req(1'b0, 1'b1, 24'h000100, 12'd40);
    step();
    set_req(1'b1, 1'b1, 24'h002000, 12'd4);
    serve(1'b0, 24'h000100, 12'd16, 16'h1000, 1'b1, 1'b0);
    serve(1'b1, 24'h002000, 12'd4,  16'h2000, 1'b1, 1'b1);
    serve(1'b0, 24'h000120, 12'd16, 16'h1010, 1'b0, 1'b0);
    serve(1'b0, 24'h000140, 12'd8,  16'h1020, 1'b0, 1'b1);
`endif

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
